hit_conditioner: RTL
====================

// Module: hit_conditioner
// PURPOSE
//  Multi-channel successor of the single-hit input filter in the TDC front end.
//  Per channel it synchronises an asynchronous hit and rejects glitches shorter than MIN_WIDTH.
//  It emits one hit_valid pulse per accepted hit, enforces a programmable dead time and
//  tags each hit with a coarse timestamp.
//  Sits between the input pins and the CARRY4 delay-line encoder / readout FIFO.
// PARAMETERS
//  NUM_CH      4   number of independent hit channels
//  SYNC_STAGES 2   synchroniser flops per channel (>=2)
//  MIN_WIDTH   2   consecutive synced-high cycles needed to accept a hit (>=1)
//  DEAD_W      8   width of dead_time input / dead counter
//  CNT_W       16  coarse counter / timestamp width
// PORTS
//  clk          in  1             system clock, all logic on rising edge
//  rst_n        in  1             synchronous reset, active low
//  enable       in  1             0: channels forced to IDLE, no new hits accepted
//  dead_time    in  DEAD_W        dead cycles after each accepted hit (0 = none)
//  hit          in  NUM_CH        raw asynchronous hit inputs
//  hit_valid    out NUM_CH        1-cycle pulse per accepted hit, per channel
//  hit_time     out NUM_CH*CNT_W  coarse timestamp, ch k at [k*CNT_W +: CNT_W]
//  coarse_cnt   out CNT_W         free-running coarse counter
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): sync flops, hit_valid, hit_time, coarse_cnt = 0; FSMs -> IDLE.
//  coarse_cnt: +1 every cycle, wraps 2^CNT_W-1 -> 0. Runs regardless of enable.
//  s[k] = last synchroniser stage; s[k] is the raw hit delayed by SYNC_STAGES cycles.
//  Per-channel FSM (all state registered):
//   IDLE     : s=1 & enable -> latch start=coarse_cnt, qcnt=1.
//              MIN_WIDTH=1: -> DEAD/WAIT_LOW and emit. Otherwise -> QUAL.
//   QUAL     : s=1 -> qcnt+1. When qcnt reaches MIN_WIDTH: emit, -> DEAD.
//              s=0 before MIN_WIDTH -> IDLE, glitch dropped, no output.
//   DEAD     : dcnt counts dead_time cycles, input ignored; at end -> WAIT_LOW.
//              dead_time=0: DEAD is skipped.
//   WAIT_LOW : stays until s=0, then -> IDLE. Re-arms only after a low cycle,
//              so one long pulse gives one hit.
//  emit: hit_valid[k]=1 for exactly one cycle. hit_time[k]=start (value at the first high
//   s sample), updated in the same cycle and held until the next emit.
//  Latency: first high s sample at cycle t -> hit_valid high at cycle t+MIN_WIDTH.
//   Raw pin to pulse = SYNC_STAGES+MIN_WIDTH cycles.
//  dead_time is sampled at emit; changes mid-DEAD do not affect the running count.
//  enable=0: every FSM -> IDLE next cycle, in-flight QUAL aborted, no emit.
//   hit_time is held; synchronisers keep running.
//  Channels are fully independent; simultaneous emits on several channels are allowed.
//  Reset mid-QUAL/DEAD: no emit, state IDLE on the cycle after reset deasserts.
//  Timestamp wrap: start is copied raw; wrap interpretation is left to readout.
// CONFIGURATION
//  HIT_CONDITIONER_CNT_EN defined: adds output hit_count (NUM_CH*16). Ch k holds a 16-bit
//   saturating count of emits (stops at 16'hFFFF). Cleared by reset only.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package tdc_pkg: FSM state encoding (IDLE, QUAL, DEAD, WAIT_LOW; 2 bits),
//   default widths.
//  Sub-module hit_chan_fsm: one channel (sync chain, qual/dead counters, FSM, timestamp
//   latch), instantiated NUM_CH times in a generate loop. Top holds coarse_cnt and
//   output packing.
// TESTING
//  1 Reset: hold rst_n=0 5 cycles with hit toggling -> all outputs 0. coarse_cnt=0,1,2 after release.
//  2 Glitch: ch0 high 1 cycle, MIN_WIDTH=2 -> no hit_valid; high 2 cycles -> one pulse at
//    SYNC_STAGES+2 cycles after the rising edge. hit_time[0] = coarse_cnt at the first synced high.
//  3 Dead time: dead_time=8, ch1 pulses every 4 cycles (2 high / 2 low) -> pulses accepted
//    once per >=12-cycle window. dead_time=0 with 3-high/1-low pulses -> each pulse accepted.
//  4 Long pulse: ch2 high 100 cycles -> exactly one hit_valid; after a low, next rise accepted.
//  5 Simultaneous/enable: all 4 channels rise together -> 4 pulses in the same cycle, equal hit_time.
//    enable dropped mid-QUAL -> no pulse.
//  6 Wrap: CNT_W=4, hit when coarse_cnt=15 -> hit_time=15; counter reads 0 next cycle.
//    With HIT_CONDITIONER_CNT_EN: 3 hits -> hit_count=3.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC hit front end: per-channel FSM encoding, default widths
// and the saturating hit-count helper.
package tdc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StQual    = 2'd1,
    StDead    = 2'd2,
    StWaitLow = 2'd3
  } chan_state_e;

  localparam int unsigned DefNumCh      = 4;
  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefMinWidth   = 2;
  localparam int unsigned DefDeadW      = 8;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned HitCountW     = 16;

  function automatic logic [HitCountW-1:0] sat_inc(input logic [HitCountW-1:0] value);
    return (value == {HitCountW{1'b1}}) ? value : value + HitCountW'(1);
  endfunction

endpackage

// File: rtl/hit_chan_fsm.sv
// One hit channel: synchroniser, glitch qualifier, dead-time FSM and timestamp latch.
// With HIT_CONDITIONER_CNT_EN defined it also keeps a saturating count of accepted hits.
module hit_chan_fsm
  import tdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned MIN_WIDTH   = DefMinWidth,
  parameter int unsigned DEAD_W      = DefDeadW,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DEAD_W-1:0]    dead_time,
  input  logic                 hit,
  input  logic [CNT_W-1:0]     coarse_cnt,
  output logic                 hit_valid,
  output logic [CNT_W-1:0]     hit_time
`ifdef HIT_CONDITIONER_CNT_EN
  ,
  output logic [HitCountW-1:0] hit_count
`endif
);

  // Holds values up to MIN_WIDTH so the "reached" compare never overflows.
  localparam int unsigned QcntW = (MIN_WIDTH > 1) ? $clog2(MIN_WIDTH + 1) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  chan_state_e            state_q, state_d;
  logic [QcntW-1:0]       qcnt_q, qcnt_d;
  logic [DEAD_W-1:0]      dcnt_q, dcnt_d;
  logic [CNT_W-1:0]       start_q, start_d;
  logic                   emit;
  logic                   hit_valid_q;
  logic [CNT_W-1:0]       hit_time_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], hit};
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    dcnt_d  = dcnt_q;
    start_d = start_q;
    emit    = 1'b0;

    if (!enable) begin
      state_d = StIdle;
      qcnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s) begin
            start_d = coarse_cnt;
            qcnt_d  = QcntW'(1);
            if (MIN_WIDTH == 1) begin
              emit = 1'b1;
            end else begin
              state_d = StQual;
            end
          end
        end
        StQual: begin
          if (!s) begin
            state_d = StIdle;
          end else if (qcnt_q + QcntW'(1) == QcntW'(MIN_WIDTH)) begin
            emit = 1'b1;
          end else begin
            qcnt_d = qcnt_q + QcntW'(1);
          end
        end
        StDead: begin
          if (dcnt_q <= DEAD_W'(1)) begin
            state_d = StWaitLow;
          end else begin
            dcnt_d = dcnt_q - DEAD_W'(1);
          end
        end
        StWaitLow: begin
          if (!s) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      // dead_time is captured here, so later changes leave a running count alone.
      if (emit) begin
        state_d = (dead_time != '0) ? StDead : StWaitLow;
        dcnt_d  = dead_time;
        qcnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      qcnt_q      <= '0;
      dcnt_q      <= '0;
      start_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_time_q  <= '0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      dcnt_q      <= dcnt_d;
      start_q     <= start_d;
      hit_valid_q <= emit;
      if (emit) begin
        hit_time_q <= start_d;
      end
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_time  = hit_time_q;

`ifdef HIT_CONDITIONER_CNT_EN
  logic [HitCountW-1:0] hit_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q <= '0;
    end else if (emit) begin
      hit_count_q <= sat_inc(hit_count_q);
    end
  end

  assign hit_count = hit_count_q;
`endif

endmodule

// File: rtl/hit_conditioner.sv
// Multi-channel hit conditioner: free-running coarse counter plus NUM_CH independent channels.
// Optional per-channel hit counters are enabled by defining HIT_CONDITIONER_CNT_EN.
module hit_conditioner
  import tdc_pkg::*;
#(
  parameter int unsigned NUM_CH      = DefNumCh,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned MIN_WIDTH   = DefMinWidth,
  parameter int unsigned DEAD_W      = DefDeadW,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DEAD_W-1:0]             dead_time,
  input  logic [NUM_CH-1:0]             hit,
  output logic [NUM_CH-1:0]             hit_valid,
  output logic [NUM_CH*CNT_W-1:0]       hit_time,
  output logic [CNT_W-1:0]              coarse_cnt
`ifdef HIT_CONDITIONER_CNT_EN
  ,
  output logic [NUM_CH*HitCountW-1:0]   hit_count
`endif
);

  logic [CNT_W-1:0] coarse_q;

  // Runs independently of enable so timestamps stay on one continuous timebase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coarse_q <= '0;
    end else begin
      coarse_q <= coarse_q + CNT_W'(1);
    end
  end

  assign coarse_cnt = coarse_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    hit_chan_fsm #(
      .SYNC_STAGES (SYNC_STAGES),
      .MIN_WIDTH   (MIN_WIDTH),
      .DEAD_W      (DEAD_W),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .dead_time  (dead_time),
      .hit        (hit[k]),
      .coarse_cnt (coarse_q),
      .hit_valid  (hit_valid[k]),
      .hit_time   (hit_time[k*CNT_W +: CNT_W])
`ifdef HIT_CONDITIONER_CNT_EN
      ,
      .hit_count  (hit_count[k*HitCountW +: HitCountW])
`endif
    );
  end

endmodule
